// File: rtl/m_ll_queue.sv
// Linked-list FIFO client of the one-hot free list allocator.
// Define LL_QUEUE_RET_SKID_EN for a 2-entry return buffer.
module m_ll_queue #(
  parameter  int EN    = 64,
  parameter  int DW    = 32,
  localparam int L2_EN = $clog2(EN),
  localparam int CNT_W = $clog2(EN+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [DW-1:0]    push_data,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [DW-1:0]    pop_data,
  input  logic             fl_vld,
  output logic             fl_rdy,
  input  logic [EN-1:0]    fl,
  output logic             ret_vld,
  input  logic             ret_rdy,
  output logic [EN-1:0]    ret,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    data_mem [EN];
  logic [L2_EN-1:0] next_mem [EN];
  logic [L2_EN-1:0] head;
  logic [L2_EN-1:0] tail;
  logic [L2_EN-1:0] idx;
  logic [EN-1:0]    ret_in;
  logic             push_fire;
  logic             pop_fire;
  logic             ret_space;
  logic             empty_after;

  assign push_rdy  = fl_vld && !flush;
  assign fl_rdy    = push_vld && push_rdy;
  assign push_fire = fl_rdy;
  assign pop_vld   = (count != '0) && ret_space && !flush;
  assign pop_fire  = pop_vld && pop_rdy;
  assign pop_data  = data_mem[head];
  assign ret_in    = {{(EN-1){1'b0}}, 1'b1} << head;

  // a push lands at the head when nothing survives this cycle's pop
  assign empty_after = (count == '0) ||
                       ((count == CNT_W'(1)) && pop_fire);

  always_comb begin
    idx = '0;
    for (int i = 0; i < EN; i++)
      if (fl[i]) idx = idx | L2_EN'(i);
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      data_mem[idx] <= push_data;
      if (!empty_after) next_mem[tail] <= idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push_fire && !pop_fire)
        count <= count + CNT_W'(1);
      else if (pop_fire && !push_fire)
        count <= count - CNT_W'(1);
      if (pop_fire) head <= next_mem[head];
      if (push_fire) begin
        tail <= idx;
        if (empty_after) head <= idx;
      end
    end
  end

`ifdef LL_QUEUE_RET_SKID_EN
  logic [EN-1:0] rbuf [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    ret_occ;
  logic          deq;

  assign deq       = ret_vld && ret_rdy;
  assign ret_vld   = ret_occ != 2'd0;
  assign ret       = ret_vld ? rbuf[rd_ptr] : '0;
  assign ret_space = (ret_occ < 2'd2) || ret_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf[0] <= '0;
      rbuf[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      ret_occ <= 2'd0;
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      ret_occ <= 2'd0;
    end else begin
      if (pop_fire) begin
        rbuf[wr_ptr] <= ret_in;
        wr_ptr       <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      ret_occ <= ret_occ + {1'b0, pop_fire} - {1'b0, deq};
    end
  end
`else
  assign ret_space = !ret_vld || ret_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_vld <= 1'b0;
      ret     <= '0;
    end else if (flush) begin
      ret_vld <= 1'b0;
      ret     <= '0;
    end else if (pop_fire) begin
      ret_vld <= 1'b1;
      ret     <= ret_in;
    end else if (ret_vld && ret_rdy) begin
      ret_vld <= 1'b0;
      ret     <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_m_ll_queue.sv
// Bench for m_ll_queue with a lowest-bit-first free list model.
// Vector table plus data/return scoreboard.
module tb_m_ll_queue;

  localparam int EN = 4;
  localparam int DW = 8;
`ifdef LL_QUEUE_RET_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          push_vld;
  logic          push_rdy;
  logic [DW-1:0] push_data;
  logic          pop_vld;
  logic          pop_rdy;
  logic [DW-1:0] pop_data;
  logic          fl_vld;
  logic          fl_rdy;
  logic [EN-1:0] fl;
  logic          ret_vld;
  logic          ret_rdy;
  logic [EN-1:0] ret;
  logic [2:0]    count;

  m_ll_queue #(.EN(EN), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_vld(push_vld), .push_rdy(push_rdy),
    .push_data(push_data),
    .pop_vld(pop_vld), .pop_rdy(pop_rdy),
    .pop_data(pop_data),
    .fl_vld(fl_vld), .fl_rdy(fl_rdy), .fl(fl),
    .ret_vld(ret_vld), .ret_rdy(ret_rdy), .ret(ret),
    .count(count)
  );

  always #5 clk = ~clk;

  // free list model: grants lowest free bit
  logic [EN-1:0] occ;
  assign fl_vld = occ != 4'hF;
  always_comb begin
    fl = '0;
    for (int i = EN-1; i >= 0; i--)
      if (!occ[i]) fl = 4'b0001 << i;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= '0;
    else if (flush) occ <= '0;
    else occ <= (occ | (fl_rdy ? fl : 4'h0)) &
                ~((ret_vld && ret_rdy) ? ret : 4'h0);
  end

  typedef struct {
    logic          pv;
    logic [DW-1:0] pd;
    logic          pr;
    logic          rr;
    logic          fs;
    logic          e_prdy;
    logic          e_pvld;
    logic [2:0]    e_cnt;
    logic          e_rvld;
    logic [EN-1:0] e_fl;
    logic          pdk;
    logic [DW-1:0] e_pd;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [EN-1:0] ent;
  } sb_t;

  sb_t           sbq [$];
  logic [EN-1:0] rq  [$];
  vec_t          vq  [$];
  int            nchk = 0;
  int            nerr = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(
    logic pv, logic [7:0] pd, logic pr, logic rr, logic fs,
    logic eprdy, logic epvld, logic [2:0] ecnt, logic ervld,
    logic [3:0] efl, logic pdk, logic [7:0] epd);
    vec_t v;
    v = '{pv, pd, pr, rr, fs, eprdy, epvld, ecnt, ervld,
          efl, pdk, epd};
    return v;
  endfunction

  task automatic cyc(input vec_t v);
    sb_t e;
    @(negedge clk);
    push_vld  = v.pv;
    push_data = v.pd;
    pop_rdy   = v.pr;
    ret_rdy   = v.rr;
    flush     = v.fs;
    #1;
    chk("push_rdy", push_rdy, v.e_prdy);
    chk("pop_vld", pop_vld, v.e_pvld);
    chk("count", count, v.e_cnt);
    chk("ret_vld", ret_vld, v.e_rvld);
    chk("fl_rdy", fl_rdy, v.pv && v.e_prdy);
    if (v.e_fl != 4'h0) chk("fl_grant", fl, v.e_fl);
    if (v.pdk) chk("pop_data_head", pop_data, v.e_pd);
    if (push_vld && push_rdy) sbq.push_back('{push_data, fl});
    if (pop_vld && pop_rdy) begin
      if (sbq.size() == 0) chk("pop_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("pop_data", pop_data, e.data);
        rq.push_back(e.ent);
      end
    end
    if (ret_vld && ret_rdy && !flush) begin
      if (rq.size() == 0) chk("ret_unexpected", 1, 0);
      else chk("ret_entry", ret, rq.pop_front());
    end
    if (flush) begin
      sbq.delete();
      rq.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; push_vld = 1'b0;
    push_data = '0; pop_rdy = 1'b0; ret_rdy = 1'b1;
    #12;
    chk("rst_count", count, 0);
    chk("rst_pop_vld", pop_vld, 0);
    chk("rst_ret_vld", ret_vld, 0);
    chk("rst_ret", ret, 0);
    @(negedge clk) rst_n = 1'b1;

    // pv pd pr rr fs | prdy pvld cnt rvld fl pdk pd
    vq.push_back(mk(1,8'h11,0,1,0, 1,0,0,0, 4'h1,0,0));
    vq.push_back(mk(1,8'h22,0,1,0, 1,1,1,0, 4'h2,0,0));
    vq.push_back(mk(1,8'h33,0,1,0, 1,1,2,0, 4'h4,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,3,0, 0,1,8'h11));
    vq.push_back(mk(0,0,1,1,0, 1,1,3,0, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 1,1,2,1, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 1,1,1,1, 0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,0,0,0, 0,0,0));
    // fill all entries, then reuse entry 0
    vq.push_back(mk(1,8'hA1,0,1,0, 1,0,0,0, 4'h1,0,0));
    vq.push_back(mk(1,8'hA2,0,1,0, 1,1,1,0, 4'h2,0,0));
    vq.push_back(mk(1,8'hA3,0,1,0, 1,1,2,0, 4'h4,0,0));
    vq.push_back(mk(1,8'hA4,0,1,0, 1,1,3,0, 4'h8,0,0));
    vq.push_back(mk(1,8'hA5,0,1,0, 0,1,4,0, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 0,1,4,0, 0,0,0));
    vq.push_back(mk(1,8'hA5,0,1,0, 0,1,3,1, 0,0,0));
    vq.push_back(mk(1,8'hA5,0,1,0, 1,1,3,0, 4'h1,0,0));
    vq.push_back(mk(0,0,1,1,0, 0,1,4,0, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 0,1,3,1, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 1,1,2,1, 0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,1,1, 0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,1,0, 0,1,8'hA5));
    // push and pop together at count 1
    vq.push_back(mk(1,8'hB1,1,1,0, 1,1,1,0, 4'h2,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,1,1, 0,1,8'hB1));
    // ret_rdy low for three cycles with two queued
    vq.push_back(mk(1,8'hB2,0,1,0, 1,1,1,0, 4'h1,0,0));
    vq.push_back(mk(0,0,1,0,0, 1,1,2,0, 0,0,0));
    vq.push_back(mk(0,0,1,0,0, 1,SKID,1,1, 0,0,0));
    vq.push_back(mk(0,0,1,0,0, 1,0,SKID ? 3'd0 : 3'd1,1, 0,0,0));
    vq.push_back(mk(0,0,1,1,0, 1,!SKID,SKID ? 3'd0 : 3'd1,1,
                    0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,0,0,0, 0,0,0));
    // flush with entries queued and a return pending
    vq.push_back(mk(1,8'hC1,0,1,0, 1,0,0,0, 4'h1,0,0));
    vq.push_back(mk(1,8'hC2,0,1,0, 1,1,1,0, 4'h2,0,0));
    vq.push_back(mk(1,8'hC3,0,1,0, 1,1,2,0, 4'h4,0,0));
    vq.push_back(mk(1,8'hC4,0,1,0, 1,1,3,0, 4'h8,0,0));
    vq.push_back(mk(0,0,1,0,0, 0,1,4,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,0,3,1, 0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1,8'hD1,0,1,0, 1,0,0,0, 4'h1,0,0));
    vq.push_back(mk(0,0,1,1,0, 1,1,1,0, 0,1,8'hD1));
    vq.push_back(mk(0,0,0,1,0, 1,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,0,0,0, 0,0,0));

    for (int i = 0; i < vq.size(); i++) cyc(vq[i]);

    // asynchronous reset in the middle of a burst
    cyc(mk(1,8'hE1,0,1,0, 1,0,0,0, 4'h1,0,0));
    cyc(mk(1,8'hE2,0,1,0, 1,1,1,0, 4'h2,0,0));
    cyc(mk(0,0,1,0,0, 1,1,2,0, 0,0,0));
    @(negedge clk);
    push_vld = 1'b0; pop_rdy = 1'b0; ret_rdy = 1'b0;
    #1;
    chk("pre_rst_ret_vld", ret_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_pop_vld", pop_vld, 0);
    chk("mid_rst_ret_vld", ret_vld, 0);
    chk("mid_rst_ret", ret, 0);
    chk("mid_rst_push_rdy", push_rdy, 1);
    sbq.delete();
    rq.delete();
    @(negedge clk) rst_n = 1'b1;
    cyc(mk(1,8'hF1,0,1,0, 1,0,0,0, 4'h1,0,0));
    cyc(mk(1,8'hF2,1,1,0, 1,1,1,0, 4'h2,0,0));
    cyc(mk(0,0,1,1,0, 1,1,1,1, 0,1,8'hF2));
    cyc(mk(0,0,0,1,0, 1,0,0,1, 0,0,0));
    cyc(mk(0,0,0,1,0, 1,0,0,0, 0,0,0));

    chk("scoreboard_drained", sbq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/m_ll_queue.md
# m_ll_queue

Single linked-list FIFO built on top of the one-hot free list allocator. It is the client end of the free-list handshakes: it consumes allocated entries on the `fl` interface to store pushed data and hands entries back on the `ret` interface when data is popped. Entry storage (data plus next pointer) lives inside this block; the free list only tracks which entries are occupied.

## Interface

Parameters:
- `EN`, 64: number of entries; must match the paired free list.
- `DW`, 32: payload width.
- `L2_EN`, `$clog2(EN)`: entry index width (local).
- `CNT_W`, `$clog2(EN+1)`: occupancy counter width (local).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `flush`, in, 1: synchronous clear of all queue state; the same wire drives the free list's `flush`.
- `push_vld`, in, 1: push request.
- `push_rdy`, out, 1: push accepted when high together with `push_vld`.
- `push_data`, in, DW: payload to enqueue.
- `pop_vld`, out, 1: head entry available.
- `pop_rdy`, in, 1: consumer takes the head.
- `pop_data`, out, DW: payload of the head entry.
- `fl_vld`, in, 1: free list has an entry.
- `fl_rdy`, out, 1: allocation strobe to the free list.
- `fl`, in, EN: one-hot free entry.
- `ret_vld`, out, 1: entry return request.
- `ret_rdy`, in, 1: free list accepts the return.
- `ret`, out, EN: one-hot returned entry.
- `count`, out, CNT_W: number of queued entries.

## Operation

- Storage: `data_mem[EN]` (DW bits each) and `next_mem[EN]` (L2_EN bits each), plus `head`, `tail` and `count` registers.
- Push:
  - `push_rdy = fl_vld && !flush`.
  - `fl_rdy = push_vld && push_rdy`.
  - On a push strobe, `idx = onehot2bin(fl)` and `data_mem[idx] <= push_data`.
  - If the queue is non-empty after any same-cycle pop, also `next_mem[tail] <= idx`.
  - `tail <= idx`.
- Pop:
  - `pop_vld = (count != 0) && ret_space && !flush`.
  - `pop_data = data_mem[head]` (combinational read).
  - On a pop strobe, `head <= next_mem[head]` and `onehot(head)` is loaded into the return buffer.
- Empty push: `head <= idx` when `count == 0`, or when `count == 1` with a same-cycle pop.
- Simultaneous push and pop: `count` is unchanged, and both the `next_mem` and `head` rules above apply.
- Return buffer (default build): one register pair `{ret_vld, ret}`.
  - It is cleared when `ret_vld && ret_rdy` and no new pop occurs that cycle.
  - `ret_space = !ret_vld || ret_rdy`.
- `count`:
  - +1 on push only, −1 on pop only.
  - It never exceeds EN, because the free list withholds `fl_vld` once all entries are allocated.
- Flush:
  - `count`, `head`, `tail` and `ret_vld` are cleared to 0 on the next edge.
  - Memories are not cleared.
  - Pending returns are dropped; the free list's own flush restores all entries.
- A non-one-hot `fl` is illegal input; the behaviour is undefined.

## Timing

- Reset values: `count=0`, `head=0`, `tail=0`, `ret_vld=0`, `ret=0`, `pop_vld=0`. `push_rdy` and `fl_rdy` follow their inputs combinationally.
- Push-to-pop latency: 1 cycle. Data pushed at edge N is visible on `pop_vld`/`pop_data` after edge N.
- Pop-to-return latency: `ret_vld` rises 1 cycle after the pop strobe. The entry is not reusable by the free list before that edge.
- Throughput: one push and one pop per cycle, as long as `ret_rdy` stays high.
- `ret_vld`/`ret` are held stable while `ret_rdy` is low.
- Reset mid-operation clears all registers immediately (asynchronous). It does not reset the memories.

## Configuration

- `LL_QUEUE_RET_SKID_EN`
  - Defined: the return buffer is a 2-entry FIFO, and `ret_space = (ret_occ < 2) || ret_rdy`. A single cycle of `ret_rdy` low does not stall pops. Returns leave in pop order.
  - Undefined: the 1-entry buffer described above, so pops stall in any cycle where `ret_vld && !ret_rdy`.

## Test plan

All scenarios use EN=4, DW=8, with the free list granting the lowest set bit first.

- Push 0x11, 0x22, 0x33 on consecutive cycles:
  - `fl` = 0001, 0010, 0100 is consumed.
  - `count` = 3.
  - Pops return 0x11, 0x22, 0x33 in order.
  - `ret` = 0001, 0010, 0100, each one cycle after its pop.
- Fill all 4 entries:
  - `fl_vld` goes low, so `push_rdy` = 0.
  - After one pop and its return is accepted, `push_rdy` = 1 and the new push reuses entry 0001.
- Simultaneous push and pop with `count`=1 (head=entry0, pushing into entry1):
  - `count` stays 1.
  - `head` = 1, and `pop_data` equals the pushed value next cycle.
- Hold `ret_rdy` = 0 for 3 cycles with 2 entries queued:
  - Default build: 1 pop, then `pop_vld` = 0 until `ret_rdy` rises.
  - `LL_QUEUE_RET_SKID_EN` build: 2 pops, and `ret` is presented in pop order.
- `flush` with 3 entries queued and `ret_vld` = 1:
  - Next cycle, `count` = 0, `pop_vld` = 0 and `ret_vld` = 0.
  - A subsequent push is granted entry 0001.
- Assert `rst_n` low mid-burst:
  - All outputs immediately take their reset values.
  - After release, push/pop ordering works from empty.
